// File: rtl/fsmc_reg_bridge.sv
// fsmc_reg_bridge: FSMC multiplexed-bus slave bridge to N_CH register channels.
// Resamples the MCU strobes, latches the multiplexed address, decodes a
// contiguous channel window and issues single-cycle write/read strobes.
// Optional build macro FSMC_BRIDGE_STAT_EN adds a read-only status channel at
// index N_CH holding {WR_CNT, RD_CNT}; a write to it clears both counters.
module fsmc_reg_bridge #(
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 19,
    parameter int                 N_CH      = 4,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 19'h58000,
    parameter int                 CH_W      = $clog2(N_CH + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     NE,
    input  logic                     NADV,
    input  logic                     NWE,
    input  logic                     NOE,
    input  logic [DATA_W-1:0]        AD_IN,
    input  logic [ADDR_W-DATA_W-1:0] A_HI,
    output logic [DATA_W-1:0]        AD_OUT,
    output logic                     AD_OE,
    output logic [CH_W-1:0]          CH_SEL,
    output logic                     WR_STB,
    output logic [DATA_W-1:0]        WR_DATA,
    output logic                     RD_STB,
    input  logic [N_CH*DATA_W-1:0]   RD_DATA,
    output logic                     HIT
);

    localparam int HI_W = ADDR_W - DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WRITE, S_READ} state_t;

    // Strobe synchronizers, packed {NE, NADV, NWE, NOE}; edge flop skips NE.
    logic [3:0]        bus_s1_q, bus_s2_q;
    logic [2:0]        bus_d3_q;
    logic [DATA_W-1:0] ad_s1_q, ad_s2_q;
    logic [HI_W-1:0]   ahi_s1_q, ahi_s2_q;

    logic ne_s, nadv_s, nwe_s, noe_s;
    logic nadv_rise, nwe_fall, nwe_rise, noe_fall, noe_rise;

    logic [ADDR_W-1:0] addr_cap_q, addr_diff;
    logic [DATA_W-1:0] wr_data_q;
    logic              ch_hit, stat_hit, acc_hit;
    logic [CH_W-1:0]   ch_sel;
    logic [DATA_W-1:0] rd_word;

    state_t            state_q, state_d;
    logic              wr_stb_q, wr_stb_d;
    logic              rd_stb_q, rd_stb_d;
    logic              ad_oe_q, ad_oe_d;
    logic [DATA_W-1:0] ad_out_q, ad_out_d;

    // Two-flop resampling of every bus input plus one delay flop for edges.
    // Reset presets everything to 1 so a reset never fabricates a bus edge.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge value of its neighbour and the chain shifts one stage.
        if (RST) begin
            bus_s1_q <= '1;
            bus_s2_q <= '1;
            bus_d3_q <= '1;
            ad_s1_q  <= '1;
            ad_s2_q  <= '1;
            ahi_s1_q <= '1;
            ahi_s2_q <= '1;
        end else begin
            bus_s1_q <= {NE, NADV, NWE, NOE};
            bus_s2_q <= bus_s1_q;
            bus_d3_q <= bus_s2_q[2:0];
            ad_s1_q  <= AD_IN;
            ad_s2_q  <= ad_s1_q;
            ahi_s1_q <= A_HI;
            ahi_s2_q <= ahi_s1_q;
        end
    end

    assign ne_s      = bus_s2_q[3];
    assign nadv_s    = bus_s2_q[2];
    assign nwe_s     = bus_s2_q[1];
    assign noe_s     = bus_s2_q[0];
    assign nadv_rise =  nadv_s & ~bus_d3_q[2];
    assign nwe_fall  = ~nwe_s  &  bus_d3_q[1];
    assign nwe_rise  =  nwe_s  & ~bus_d3_q[1];
    assign noe_fall  = ~noe_s  &  bus_d3_q[0];
    assign noe_rise  =  noe_s  & ~bus_d3_q[0];

    // Track the bus while NADV/NWE are low; the last value before the rising
    // edge is what stays latched.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_cap_q <= '0;
            wr_data_q  <= '0;
        end else begin
            if (!nadv_s) addr_cap_q <= {ahi_s2_q, ad_s2_q};
            if (!nwe_s)  wr_data_q  <= ad_s2_q;
        end
    end

    // Window decode: one unsigned subtract covers both ends, because an
    // address below BASE_ADDR wraps to a huge offset.
    assign addr_diff = addr_cap_q - BASE_ADDR;
    assign ch_hit    = addr_diff < ADDR_W'(N_CH);
`ifdef FSMC_BRIDGE_STAT_EN
    assign stat_hit  = addr_diff == ADDR_W'(N_CH);
`else
    assign stat_hit  = 1'b0;
`endif
    assign acc_hit   = ch_hit | stat_hit;
    assign ch_sel    = acc_hit ? addr_diff[CH_W-1:0] : '0;

    // Read-data mux over the flattened channel bus.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rd_word = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_sel == CH_W'(k)) rd_word = RD_DATA[k*DATA_W +: DATA_W];
        end
    end

`ifdef FSMC_BRIDGE_STAT_EN
    logic [7:0]        wr_cnt_q, rd_cnt_q;
    logic              stat_clr;
    logic [DATA_W-1:0] stat_word;

    assign stat_clr  = (state_q == S_WRITE) && nwe_rise && stat_hit;
    assign stat_word = DATA_W'({wr_cnt_q, rd_cnt_q});

    // Hit-strobe counters; 8-bit natural wrap, cleared by a status write.
    always_ff @(posedge CLK) begin
        if (RST || stat_clr) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_stb_d) wr_cnt_q <= wr_cnt_q + 8'd1;
            if (rd_stb_d) rd_cnt_q <= rd_cnt_q + 8'd1;
        end
    end
`endif

    // Access FSM next state, strobes and registered pad data.
    always_comb begin
        state_d  = state_q;
        wr_stb_d = 1'b0;
        ad_out_d = ad_out_q;
        unique case (state_q)
            S_IDLE:  if (nadv_rise && !ne_s) state_d = S_ADDR;
            S_ADDR: begin
                if (nwe_fall)      state_d = S_WRITE;
                else if (noe_fall) state_d = S_READ;
            end
            S_WRITE: begin
                // Evaluated before the NE override so a write ending together
                // with chip-select still strobes.
                if (nwe_rise) begin
                    state_d  = S_ADDR;
                    wr_stb_d = ch_hit;
                end
            end
            S_READ: begin
                if (noe_rise) state_d = S_ADDR;
                if (acc_hit) begin
`ifdef FSMC_BRIDGE_STAT_EN
                    ad_out_d = stat_hit ? stat_word : rd_word;
`else
                    ad_out_d = rd_word;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (ne_s) state_d = S_IDLE;
        rd_stb_d = (state_q != S_READ) && (state_d == S_READ) && ch_hit;
        ad_oe_d  = (state_d == S_READ) && acc_hit;
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            wr_stb_q <= 1'b0;
            rd_stb_q <= 1'b0;
            ad_oe_q  <= 1'b0;
            ad_out_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_stb_q <= wr_stb_d;
            rd_stb_q <= rd_stb_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
        end
    end

    assign AD_OUT  = ad_out_q;
    assign AD_OE   = ad_oe_q;
    assign CH_SEL  = ch_sel;
    assign WR_STB  = wr_stb_q;
    assign WR_DATA = wr_data_q;
    assign RD_STB  = rd_stb_q;
    assign HIT     = acc_hit;

endmodule

// File: doc/fsmc_reg_bridge.md
# fsmc_reg_bridge

Synchronous FSMC slave bridge between the STM32 multiplexed address/data bus (NE, NADV, NWE, NOE, AD[15:0] plus upper address lines) and a bank of N_CH FPGA register channels. All MCU bus strobes are resampled into the FPGA clock domain. The bridge latches the multiplexed address, decodes a contiguous channel window, and produces single-cycle write and read strobes with channel index and data. Downstream DDS RAM, frequency-word registers and ADC FIFOs attach to it in place of per-device ad-hoc decoders.

## Interface
- DATA_W, 16, data/low-address width of the multiplexed bus
- ADDR_W, 19, full MCU address width; upper lines = ADDR_W-DATA_W bits
- N_CH, 4, number of register channels (1..64)
- BASE_ADDR, 19'h58000, first channel address; window is BASE_ADDR .. BASE_ADDR+N_CH-1
- CH_W, $clog2(N_CH+1), channel index width

Ports:
- CLK  in  1  system clock; single clock domain
- RST  in  1  reset; synchronous, active-high
- NE  in  1  chip enable from MCU, active-low
- NADV  in  1  address valid, active-low
- NWE  in  1  write enable, active-low
- NOE  in  1  output enable, active-low
- AD_IN  in  DATA_W  multiplexed bus, input side
- A_HI  in  ADDR_W-DATA_W  upper address lines (A16..)
- AD_OUT  out  DATA_W  read data to pad
- AD_OE  out  1  pad output enable, active-high
- CH_SEL  out  CH_W  decoded channel index of current access
- WR_STB  out  1  one-cycle write pulse
- WR_DATA  out  DATA_W  write data, valid with WR_STB
- RD_STB  out  1  one-cycle read pulse (FIFO pop)
- RD_DATA  in  N_CH*DATA_W  flattened channel read data, channel k at [k*DATA_W +: DATA_W]
- HIT  out  1  latched address is inside window

## Operation
- NE, NADV, NWE, NOE, AD_IN, A_HI each pass a 2-flop synchronizer (`_s` signals); strobes get one extra flop for edge detection.
- Address capture: while NADV_s=0, ADDR_CAP <= {A_HI_s, AD_IN_s} every cycle; value frozen at NADV_s rising.
- Decode: HIT = (ADDR_CAP - BASE_ADDR) < N_CH, unsigned ADDR_W-bit subtract; CH_SEL = low CH_W bits of the difference; CH_SEL = 0 on miss.
- Write data capture: while NWE_s=0, WR_DATA <= AD_IN_s every cycle; frozen at NWE_s rising.
- FSM states: IDLE, ADDR, WRITE, READ.
  - IDLE -> ADDR on NADV_s rising with NE_s=0.
  - ADDR -> WRITE on NWE_s falling; ADDR -> READ on NOE_s falling.
  - WRITE -> ADDR on NWE_s rising. WR_STB=1 for that one cycle if HIT.
  - READ: on entry, RD_STB=1 for one cycle if HIT. AD_OUT <= RD_DATA[CH_SEL] and AD_OE=1 while in READ and HIT. READ -> ADDR on NOE_s rising; AD_OE drops in the same cycle.
  - Any state -> IDLE when NE_s=1. A pending write whose NWE_s rising coincides with NE_s rising still issues WR_STB.
  - NADV_s rising in ADDR re-latches the address; burst or back-to-back accesses need no IDLE.
- Miss: no WR_STB or RD_STB, AD_OE stays 0, HIT=0.
- Reset: state IDLE; AD_OUT=0, AD_OE=0, WR_STB=0, RD_STB=0, WR_DATA=0, CH_SEL=0, HIT=0, ADDR_CAP=0, synchronizers preset to 1 (bus idle). Reset mid-access aborts it; no strobe is generated for that access.

## Timing
- Pin edge to detected edge: 3 CLK.
- WR_STB asserts 3 CLK after the NWE pin rising edge. RD_STB and AD_OE assert 3 CLK after the NOE pin falling edge. AD_OUT is valid 4 CLK after the NOE pin falling edge (registered mux).
- AD_OE deasserts 3 CLK after the NOE pin rising edge.
- MCU FSMC timing requirements: ADDSET >= 4 CLK, DATAST >= 6 CLK, bus turnaround >= 4 CLK.
- RD_DATA is sampled in the cycle after RD_STB. A consumer popping on RD_STB must present the popped word within 1 CLK.

## Configuration
- FSMC_BRIDGE_STAT_EN defined:
  - Adds read-only channel index N_CH at BASE_ADDR+N_CH.
  - Read value: {WR_CNT[7:0], RD_CNT[7:0]}, zero-extended or truncated to DATA_W. WR_CNT and RD_CNT count hit strobes on channels 0..N_CH-1 and wrap at 255.
  - A write to index N_CH clears both counters and does not pulse WR_STB.
  - Reset clears both counters.
- FSMC_BRIDGE_STAT_EN undefined: BASE_ADDR+N_CH is a miss; no counters are built.

## Test plan
- Reset: assert RST with bus toggling -> all outputs 0, state IDLE, no strobes.
- Write ch2: address BASE_ADDR+2, data 16'hA5C3, NWE low 8 CLK -> WR_STB exactly one pulse 3 CLK after NWE rising, CH_SEL=2, WR_DATA=16'hA5C3.
- Read ch1 with RD_DATA ch1 = 16'h1234 -> RD_STB one pulse, AD_OE high while NOE is low (offset 3 CLK), AD_OUT=16'h1234. AD_OE=0 3 CLK after NOE rising.
- Miss: address BASE_ADDR+N_CH+1 (or BASE_ADDR-1 to test wrap) with write and read -> HIT=0, no strobes, AD_OE never asserts.
- Abort: RST during NWE low -> no WR_STB. The following normal write to ch0 succeeds.
- With FSMC_BRIDGE_STAT_EN: 3 writes and 2 reads on ch0 -> status read returns 16'h0302. Write to the status address -> next status read returns 16'h0000. 256 writes -> WR_CNT wraps to 0.
